// File: rtl/fifo_access_ctrl.sv
// Shares the FIFO write port between two producers (round-robin) and drains
// its read port to a single valid/ready consumer with one read in flight.
module fifo_access_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] data0,
    output logic                  gnt0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  gnt1,
    output logic                  fifo_write_en,
    output logic [DATA_WIDTH-1:0] fifo_data_in,
    input  logic                  fifo_full,
    output logic                  fifo_read_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  gnt_cnt0,
    output logic [CNT_WIDTH-1:0]  gnt_cnt1
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // ptr_q = 0: producer 0 wins a tie, ptr_q = 1: producer 1 wins
    logic                  ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;
    logic                  rd_pending_q, rd_pending_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    // Write arbitration; grants are forced low while reset is asserted
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        fifo_data_in = '0;
        if (rst && !fifo_full) begin
            if (req0 && (!req1 || !ptr_q)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
        if (gnt0) begin
            fifo_data_in = data0;
        end else if (gnt1) begin
            fifo_data_in = data1;
        end
        fifo_write_en = gnt0 | gnt1;
    end

    always_comb begin
        ptr_d  = ptr_q;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (gnt0) begin
            ptr_d = 1'b1;
        end else if (gnt1) begin
            ptr_d = 1'b0;
        end
        if (gnt0 && (cnt0_q != CNT_MAX)) begin
            cnt0_d = cnt0_q + CNT_WIDTH'(1);
        end
        if (gnt1 && (cnt1_q != CNT_MAX)) begin
            cnt1_d = cnt1_q + CNT_WIDTH'(1);
        end
    end

    // Read sequencer: issue, wait one cycle for data_out, then capture
    always_comb begin
        fifo_read_en = rst && !fifo_empty && !rd_pending_q && (!out_valid_q || out_ready);
        rd_pending_d = rd_pending_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        if (rd_pending_q) begin
            rd_pending_d = 1'b0;
        end
        if (fifo_read_en) begin
            rd_pending_d = 1'b1;
        end
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (rd_pending_q) begin
            out_valid_d = 1'b1;
            out_data_d  = fifo_data_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q        <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            rd_pending_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            rd_pending_q <= rd_pending_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign gnt_cnt0  = cnt0_q;
    assign gnt_cnt1  = cnt1_q;

endmodule

// File: doc/fifo_access_ctrl.md
Name: fifo_access_ctrl

Overview:
Controller that shares the 16x8 FIFO write port between two producers and drains its read port to a single consumer. Write side: registered round-robin arbiter with req/gnt handshake. Read side: read sequencer that issues FIFO read_en, captures data_out one cycle later and presents it on a valid/ready interface. Sits between producer/consumer logic and the fifo instance; drives the fifo's write_en, read_en and data_in, and observes its full, empty and data_out.

Parameters:
DATA_WIDTH, 8, width of producer, FIFO and consumer data.
CNT_WIDTH, 16, width of per-producer saturating grant counters.

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
req0  input  1  producer 0 write request
data0  input  DATA_WIDTH  producer 0 data, sampled when gnt0=1
gnt0  output  1  producer 0 grant, combinational, write occurs this cycle
req1  input  1  producer 1 write request
data1  input  DATA_WIDTH  producer 1 data
gnt1  output  1  producer 1 grant
fifo_write_en  output  1  to fifo write_en
fifo_data_in  output  DATA_WIDTH  to fifo data_in
fifo_full  input  1  from fifo full
fifo_read_en  output  1  to fifo read_en
fifo_empty  input  1  from fifo empty
fifo_data_out  input  DATA_WIDTH  from fifo data_out, valid the cycle after read_en sampled
out_valid  output  1  consumer data valid
out_data  output  DATA_WIDTH  consumer data
out_ready  input  1  consumer accepts when out_valid && out_ready
gnt_cnt0  output  CNT_WIDTH  writes granted to producer 0, saturating
gnt_cnt1  output  CNT_WIDTH  writes granted to producer 1, saturating

Behaviour:
- Reset (rst=0, async): out_valid=0, out_data=0, gnt_cnt0/1=0, rd_pending=0, priority pointer=producer 0. gnt0/gnt1/fifo_write_en/fifo_read_en are 0 while in reset regardless of other inputs.
- Write arbitration, combinational each cycle:
  - No grant when fifo_full=1, even if a read occurs the same cycle.
  - Otherwise exactly one requester is granted. A lone requester wins. If both request, the pointer holder wins.
  - fifo_write_en = gnt0|gnt1. fifo_data_in = winner's data; 0 when no grant.
- Pointer: after a cycle with a grant, the pointer moves to the non-granted producer. With no grant it is unchanged. Two continuously requesting producers alternate 0,1,0,1.
- Counters: gnt_cntN increments on each gntN cycle and holds at all-ones.
- Read sequencer, internal rd_pending flag:
  - fifo_read_en = !fifo_empty && !rd_pending && (!out_valid || out_ready).
  - The cycle after fifo_read_en: rd_pending=1 (set at the read edge). On the next edge, out_data<=fifo_data_out, out_valid<=1, rd_pending<=0.
  - Handshake: out_valid && out_ready clears out_valid at the edge unless new data is captured at that same edge; capture takes priority.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - At most one read in flight. Peak drain rate is 1 word per 2 cycles.
  - Read latency, FIFO non-empty to out_valid: 2 cycles.
- Write and read in the same cycle are independent; both may occur.
- Mid-operation reset: an in-flight read is discarded, out_valid drops immediately, and the pointer returns to producer 0.
- No combinational path from out_ready to gnt0/gnt1.

Test Plan:
1. Reset then req0=1, data0=8'hA5, empty FIFO -> gnt0=1 same cycle, fifo_write_en=1, fifo_data_in=8'hA5, gnt_cnt0=1 next edge.
2. req0=req1=1 for 6 cycles, data0=8'h10+n, data1=8'h20+n -> grant order 0,1,0,1,0,1; gnt_cnt0=gnt_cnt1=3.
3. Fill FIFO with 16 writes (fifo_full=1), req1 held -> gnt1=0, fifo_write_en=0 while full. After one read clears full -> gnt1=1.
4. FIFO holds 8'h11,8'h22,8'h33, out_ready=1 -> fifo_read_en pulses every 2nd cycle; out_data sequence 11,22,33, each out_valid for 1 cycle; first out_valid 2 cycles after first read_en.
5. out_ready=0 with data 8'h5A captured -> out_valid stays 1, out_data=8'h5A, no further fifo_read_en. Raise out_ready -> next read issues same cycle.
6. Assert rst=0 the cycle after fifo_read_en -> out_valid=0 and gnt0/gnt1=0 immediately; counters=0. After release, equal requests grant producer 0 first.
